filter_capture: RTL and testbench

- Capture and readback buffer at the output side of the moving-average Filter.
- Records a programmed number of consecutive Average_out samples into an internal buffer on command.
- Presents the samples to a host one at a time through a request/valid read port.
- Lets hardware or a bench controller collect filter results without sampling the live output every cycle.

---
 rtl/filter_capture.sv | 157 +++++++++++++++
 tb/tb_filter_capture.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/filter_capture.sv
// -----------------------------------------------------------------------------
// filter_capture
//   Capture and readback buffer placed after the moving-average filter.
//   A start pulse arms a run that records a programmed number of consecutive
//   valid filter samples; afterwards a host drains them one per request.
//
// Parameters
//   DATA_W : width of each captured sample
//   DEPTH  : buffer entries, power of two in 2..128
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous, active-low reset
//   start    : one-cycle pulse, begins a capture run (ignored while capturing)
//   num      : samples to capture, latched on start (0 or >DEPTH -> DEPTH)
//   in_data  : filter output sample
//   in_valid : in_data valid this cycle
//   rd_req   : host requests the next captured sample
//   rd_data  : sample returned for a read (held until next read/start/reset)
//   rd_valid : one-cycle pulse, rd_data valid
//   busy     : capture in progress
//   done     : capture complete, buffer readable
//   empty    : done and every captured sample has been read
//   overrun  : sticky, a sample arrived while holding a completed capture
//   level    : captured-but-unread sample count
// -----------------------------------------------------------------------------
module filter_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
    output logic              empty,
    output logic              overrun,
    output logic [7:0]        level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH is at most 128, so it always fits the 8-bit count domain.
    localparam logic [7:0] DEPTH_C = 8'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        wr_ptr;
    logic [7:0]        rd_ptr;
    logic [7:0]        target;
    logic [7:0]        wr_ptr_inc;
    logic              arm;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] mem [DEPTH];

    // Out-of-range requests (including 0) mean "fill the whole buffer".
    function automatic logic [7:0] clamp_num(input logic [7:0] n);
        if (n == 8'd0 || n > DEPTH_C) begin
            return DEPTH_C;
        end
        return n;
    endfunction

    assign wr_ptr_inc = wr_ptr + 8'd1;

    // While capturing, nothing has been read yet, so the write count is the level.
    assign level   = (state == CAPTURE) ? wr_ptr : (wr_ptr - rd_ptr);
    assign busy    = (state == CAPTURE);
    assign done    = (state == DONE);
    assign empty   = done && (level == 8'd0);

    always_comb begin
        state_nxt = state;
        arm       = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_ptr_inc == target) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // A re-arm takes priority over a coincident read request.
                if (start) begin
                    arm       = 1'b1;
                    state_nxt = CAPTURE;
                end else if (rd_req && level != 8'd0) begin
                    rd_en = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wr_ptr   <= 8'd0;
            rd_ptr   <= 8'd0;
            target   <= 8'd0;
            overrun  <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rd_en;
            if (arm) begin
                target  <= clamp_num(num);
                wr_ptr  <= 8'd0;
                rd_ptr  <= 8'd0;
                overrun <= 1'b0;
                rd_data <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr_inc;
                end
                if (rd_en) begin
                    rd_ptr  <= rd_ptr + 8'd1;
                    rd_data <= mem[rd_ptr[AW-1:0]];
                end
                if (state == DONE && in_valid) begin
                    overrun <= 1'b1;
                end
            end
        end
    end

    // Buffer storage carries no reset; contents are only meaningful below wr_ptr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_filter_capture.sv
module tb_filter_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        num = 8'd0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              rd_req = 1'b0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              done;
    logic              empty;
    logic              overrun;
    logic [7:0]        level;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DATA_W-1:0] exp_q[$];

    filter_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .num(num),
        .in_data(in_data), .in_valid(in_valid), .rd_req(rd_req),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .empty(empty), .overrun(overrun), .level(level)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Monitor: every read pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst && rd_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got rd_valid with 0x%02h, none expected", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_bad++;
                    $display("FAIL rd_data: got 0x%02h, expected 0x%02h", rd_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_run(input logic [7:0] n);
        num   = n;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [DATA_W-1:0] d);
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic read_one(input logic [DATA_W-1:0] e);
        exp_q.push_back(e);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_empty", empty, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_level", level, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // Normal run of 4, with start and rd_req poked while busy
        arm_run(8'd4);
        chk("n_busy", busy, 1);
        chk("n_level0", level, 0);
        feed(8'h10);
        in_data = 8'h20; in_valid = 1'b1; start = 1'b1; num = 8'd1; rd_req = 1'b1;
        step();
        in_valid = 1'b0; start = 1'b0; rd_req = 1'b0;
        chk("n_rdv_busy", rd_valid, 0);
        chk("n_start_ignored_lvl", level, 2);
        chk("n_still_busy", busy, 1);
        feed(8'h30);
        chk("n_busy3", busy, 1);
        feed(8'h40);
        chk("n_done", done, 1);
        chk("n_busy_off", busy, 0);
        chk("n_level4", level, 4);
        // Sample arriving after completion is dropped and flagged
        feed(8'hEE);
        chk("ovr_set", overrun, 1);
        chk("ovr_level", level, 4);
        rd_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'((i + 1) * 16));
            step();
            chk("n_level_drain", level, 32'(3 - i));
        end
        rd_req = 1'b0;
        step();
        chk("n_empty", empty, 1);
        chk("n_rdv_idle", rd_valid, 0);
        chk("n_ovr_sticky", overrun, 1);

        // Gapped input, num=3
        arm_run(8'd3);
        chk("g_ovr_clr", overrun, 0);
        feed(8'hA1);
        in_data = 8'h5A; step(); step();
        feed(8'hA2);
        step();
        chk("g_busy", busy, 1);
        feed(8'hA3);
        chk("g_done", done, 1);
        chk("g_level", level, 3);
        read_one(8'hA1); read_one(8'hA2); read_one(8'hA3);
        step();
        chk("g_empty", empty, 1);

        // Clamp: num=0 then num=40 both capture 16
        for (int r = 0; r < 2; r++) begin
            arm_run(r == 0 ? 8'd0 : 8'd40);
            for (int i = 0; i < 16; i++) begin
                if (i == 15) chk("c_busy15", busy, 1);
                feed(8'(i * 7 + r * 3 + 1));
            end
            chk("c_done", done, 1);
            chk("c_level", level, 16);
            rd_req = 1'b1;
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(8'(i * 7 + r * 3 + 1));
                step();
            end
            step();  // 17th request
            rd_req = 1'b0;
            chk("c_17th_rdv", rd_valid, 0);
            chk("c_17th_hold", rd_data, 32'(15 * 7 + r * 3 + 1));
            chk("c_empty", empty, 1);
        end

        // Simultaneous start + rd_req in DONE with level=2
        arm_run(8'd4);
        feed(8'h01); feed(8'h02); feed(8'h03); feed(8'h04);
        read_one(8'h01); read_one(8'h02);
        feed(8'hFF);
        chk("s_ovr_pre", overrun, 1);
        chk("s_level2", level, 2);
        num = 8'd2; start = 1'b1; rd_req = 1'b1;
        step();
        start = 1'b0; rd_req = 1'b0;
        chk("s_rdv", rd_valid, 0);
        chk("s_busy", busy, 1);
        chk("s_ovr", overrun, 0);
        feed(8'h55); feed(8'h66);
        chk("s_done", done, 1);
        read_one(8'h55); read_one(8'h66);

        // Reset mid-capture
        arm_run(8'd5);
        feed(8'h21); feed(8'h22);
        rst = 1'b0;
        #2;
        chk("r_busy", busy, 0);
        chk("r_done", done, 0);
        chk("r_level", level, 0);
        chk("r_rd_data", rd_data, 0);
        chk("r_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();
        arm_run(8'd2);
        feed(8'h77); feed(8'h88);
        chk("r2_done", done, 1);
        chk("r2_level", level, 2);
        read_one(8'h77); read_one(8'h88);
        step(); step();
        chk("r2_empty", empty, 1);
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
